// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Scans one digit per DIV-cycle slot and latches a whole frame at once so digits never tear.
module seg_scan_driver #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_content,
    input  logic [7:0]  seg_dp,
    input  logic [7:0]  seg_en,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int             CW      = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   sh_content;
    logic [7:0]    sh_dp;
    logic [7:0]    sh_en;

    logic          slot_end;
    logic          frame_end;
    logic          in_blank;
    logic          lit;
    logic [3:0]    nib;

    // Active-high gfedcba glyphs for hex digits 0..F.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    // With no blanking, a "cnt < 0" compare would be constant; drop it entirely instead.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cnt < CW'(BLANK));
        end
    endgenerate

    always_comb begin
        slot_end  = (cnt == CNT_MAX);
        frame_end = slot_end && (idx == 3'd7);
        nib       = sh_content[{idx, 2'b00} +: 4];
        lit       = sh_en[idx] && !in_blank;
    end

    // NOTE: non-blocking throughout, so every output sees the pre-edge cnt, idx and shadows;
    // the shadows are reset too so the display stays dark until the first full frame load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            sh_content <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame      <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 3'd1;
            end
            if (frame_end) begin
                sh_content <= seg_content;
                sh_dp      <= seg_dp;
                sh_en      <= seg_en;
            end
            an    <= lit ? ~(8'b1 << idx)   : 8'hFF;
            seg   <= lit ? ~decode(nib)     : 7'h7F;
            dp    <= lit ? ~sh_dp[idx]      : 1'b1;
            frame <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: DIV=4/BLANK=1 and DIV=2/BLANK=0 instances checked every cycle
// against an edge-count model, plus hand-computed pin values.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [31:0] seg_content;
    logic [7:0]  seg_dp;
    logic [7:0]  seg_en;
    logic [7:0]  a_an,  b_an;
    logic [6:0]  a_seg, b_seg;
    logic        a_dp,  b_dp;
    logic        a_frame, b_frame;

    int n_checks = 0;
    int n_err    = 0;
    int e        = 0;

    localparam logic [6:0]  GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [16:0] DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

    seg_scan_driver #(.DIV(4), .BLANK(1)) u_a (
        .clk(clk), .rst(rst), .seg_content(seg_content), .seg_dp(seg_dp), .seg_en(seg_en),
        .an(a_an), .seg(a_seg), .dp(a_dp), .frame(a_frame)
    );

    seg_scan_driver #(.DIV(2), .BLANK(0)) u_b (
        .clk(clk), .rst(rst), .seg_content(seg_content), .seg_dp(seg_dp), .seg_en(seg_en),
        .an(b_an), .seg(b_seg), .dp(b_dp), .frame(b_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Pins after an edge, given how many edges since reset release preceded it (k).
    function automatic logic [16:0] model_out(input int k, input int div, input int blank,
                                              input logic [31:0] c, input logic [7:0] d,
                                              input logic [7:0] en);
        int   p;
        int   slot;
        int   ph;
        logic fr;
        p    = k % (8 * div);
        slot = p / div;
        ph   = p % div;
        fr   = (p == 8 * div - 1);
        if (ph < blank || !en[slot]) return {8'hFF, 7'h7F, 1'b1, fr};
        return {~(8'd1 << slot), ~GLYPH[int'((c >> (4 * slot)) & 32'hF)], ~d[slot], fr};
    endfunction

    int          a_k = 0, b_k = 0;
    logic [31:0] a_c = '0, b_c = '0;
    logic [7:0]  a_d = '0, b_d = '0, a_en = '0, b_en = '0;
    logic [16:0] a_exp = DARK, b_exp = DARK;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            a_k = 0; a_c = '0; a_d = '0; a_en = '0; a_exp = DARK;
            b_k = 0; b_c = '0; b_d = '0; b_en = '0; b_exp = DARK;
        end else begin
            a_exp = model_out(a_k, 4, 1, a_c, a_d, a_en);
            b_exp = model_out(b_k, 2, 0, b_c, b_d, b_en);
            if (a_k % 32 == 31) begin a_c = seg_content; a_d = seg_dp; a_en = seg_en; end
            if (b_k % 16 == 15) begin b_c = seg_content; b_d = seg_dp; b_en = seg_en; end
            a_k = a_k + 1;
            b_k = b_k + 1;
        end
    end

    initial forever begin
        @(negedge clk);
        check("a_pins",   {15'd0, a_an, a_seg, a_dp, a_frame}, {15'd0, a_exp});
        check("b_pins",   {15'd0, b_an, b_seg, b_dp, b_frame}, {15'd0, b_exp});
        check("a_onehot", 32'($countones(~a_an) <= 1), 32'd1);
        check("b_onehot", 32'($countones(~b_an) <= 1), 32'd1);
    end

    task automatic step_to(input int target);
        repeat (target - e) @(posedge clk);
        e = target;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        seg_content = 32'h0012_3456;
        seg_dp      = 8'h00;
        seg_en      = 8'h3F;
        #1 rst = 1'b1;
        #11 rst = 1'b0;
        e = 0;

        step_to(1);   check("dark_e1_an", a_an, 8'hFF); check("dark_e1_frame", a_frame, 0);
        step_to(16);  check("b_frame16", b_frame, 1);   check("b_an16", b_an, 8'hFF);
        step_to(17);  check("b_an17", b_an, 8'hFE);     check("b_seg17", b_seg, 7'h02);
        step_to(19);  check("b_an19", b_an, 8'hFD);     check("b_seg19", b_seg, 7'h12);
        step_to(32);  check("a_frame32", a_frame, 1);   check("a_an32", a_an, 8'hFF);
        step_to(33);  check("a_frame33", a_frame, 0);   check("a_an33", a_an, 8'hFF);
        step_to(34);  check("a_an34", a_an, 8'hFE);     check("a_seg34", a_seg, 7'h02);
        check("a_dp34", a_dp, 1);
        step_to(38);  check("a_an38", a_an, 8'hFD);     check("a_seg38", a_seg, 7'h12);

        step_to(40);
        seg_content = 32'hFEDC_BA98;
        seg_en      = 8'hFF;
        seg_dp      = 8'h15;
        step_to(58);  check("a_an58_old_en", a_an, 8'hFF);
        step_to(66);  check("a_an66", a_an, 8'hFE);     check("a_seg66", a_seg, 7'h00);
        check("a_dp66", a_dp, 0);
        step_to(70);  check("a_an70", a_an, 8'hFD);     check("a_seg70", a_seg, 7'h10);
        check("a_dp70", a_dp, 1);

        step_to(78);
        seg_content = 32'h7654_3210;
        seg_dp      = 8'hAA;
        step_to(82);  check("a_an82", a_an, 8'hEF);     check("a_seg82_old", a_seg, 7'h46);
        step_to(94);  check("a_an94", a_an, 8'h7F);     check("a_seg94", a_seg, 7'h0E);
        step_to(96);  check("a_frame96", a_frame, 1);
        step_to(114); check("a_an114", a_an, 8'hEF);    check("a_seg114_new", a_seg, 7'h19);
        step_to(119); check("a_an119", a_an, 8'hDF);    check("a_seg119", a_seg, 7'h12);

        #1 rst = 1'b1;
        #1;
        check("rst_an", a_an, 8'hFF);   check("rst_seg", a_seg, 7'h7F);
        check("rst_dp", a_dp, 1);       check("rst_frame", a_frame, 0);
        check("rst_b_an", b_an, 8'hFF);
        #4 rst = 1'b0;
        e = 0;

        step_to(31);  check("post_rst_frame31", a_frame, 0);
        step_to(32);  check("post_rst_frame32", a_frame, 1);
        step_to(34);  check("post_rst_an34", a_an, 8'hFE); check("post_rst_seg34", a_seg, 7'h40);
        check("post_rst_dp34", a_dp, 1);
        step_to(70);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
